program_loader: RTL and testbench

//  Write-side counterpart of the MIPS instruction-fetch path. Receives a byte stream (UART RX side of
//  the debug unit) and assembles big-endian 32-bit instructions. Writes them sequentially into program

---
 rtl/mips_loader_pkg.sv | 6 +
 rtl/program_loader_byte_assembler.sv | 27 ++
 rtl/program_loader.sv | 95 +++++++++
 tb/tb_program_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: shared state encoding and protocol constants for the program loader
package mips_loader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, ERROR = 2'd3} state_e;
  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [31:0] HALT_INSTR = 32'hFFFFFFFF;
endpackage

// File: rtl/program_loader_byte_assembler.sv
// byte_assembler: packs bytes MSB first into a word, flagging the 4th byte combinationally
module byte_assembler #(
  parameter int NB_INSTRUC = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_rx_done,
  input  logic [7:0]            i_rx_data,
  output logic [NB_INSTRUC-1:0] o_word,
  output logic                  o_word_valid
);
  logic [NB_INSTRUC-9:0] bytes_q;
  logic [1:0]            cnt_q;
  // the 4th byte is taken straight from the input so the word is ready on its strobe
  assign o_word = {bytes_q, i_rx_data};
  assign o_word_valid = i_rx_done && cnt_q == 2'd3;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      bytes_q <= '0;
      cnt_q   <= '0;
    end else if (i_rx_done) begin
      bytes_q <= {bytes_q[NB_INSTRUC-17:0], i_rx_data};
      cnt_q   <= cnt_q + 2'd1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: writes a received byte stream as words into program memory,
// holding the CPU in reset until the HALT word has been stored.
module program_loader
  import mips_loader_pkg::*;
#(
  parameter int NB_INSTRUC        = 32,
  parameter int RAM_DEPTH_PROGRAM = 2048,
  parameter int NB_PC_ADDR        = $clog2(RAM_DEPTH_PROGRAM)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  output logic                  o_wr_en,
  output logic [NB_PC_ADDR-1:0] o_wr_addr,
  output logic [NB_INSTRUC-1:0] o_wr_data,
  output logic                  o_cpu_rst,
  output logic                  o_load_done,
  output logic                  o_error,
  output logic [NB_PC_ADDR:0]   o_word_count
);
  localparam logic [NB_PC_ADDR-1:0] LAST_ADDR = NB_PC_ADDR'(RAM_DEPTH_PROGRAM - 1);
  state_e                state_q, state_d;
  logic [NB_PC_ADDR-1:0] addr_q, addr_d;
  logic [NB_PC_ADDR:0]   count_q, count_d;
  logic [NB_INSTRUC-1:0] wr_data_q, wr_data_d, word;
  logic                  wr_en_q, wr_en_d, cpu_rst_q, load_done_q, load_done_d, error_q;
  logic                  clear, word_valid, is_cmd;
  byte_assembler #(.NB_INSTRUC(NB_INSTRUC)) u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (clear),
    .i_rx_done    (i_rx_done && state_q == LOAD),
    .i_rx_data    (i_rx_data),
    .o_word       (word),
    .o_word_valid (word_valid)
  );
  assign is_cmd = i_rx_done && i_rx_data == CMD_LOAD;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    clear     = 1'b0;
    // progress is booked in the write cycle; the last address is held on overflow
    if (wr_en_q) begin
      count_d = count_q + 1'b1;
      addr_d  = addr_q == LAST_ADDR ? addr_q : addr_q + 1'b1;
    end
    case (state_q)
      IDLE, DONE: if (is_cmd) begin
        state_d = LOAD;
        addr_d  = '0;
        count_d = '0;
        clear   = 1'b1;
      end
      LOAD: if (word_valid) begin
        wr_en_d   = 1'b1;
        wr_data_d = word;
        state_d   = word == NB_INSTRUC'(HALT_INSTR) ? DONE : addr_q == LAST_ADDR ? ERROR : LOAD;
      end
      default: ;
    endcase
    load_done_d = state_q == DONE && state_d == DONE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      cpu_rst_q   <= !load_done_d;
      load_done_q <= load_done_d;
      error_q     <= state_q == ERROR;
    end
  end
  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_cpu_rst    = cpu_rst_q;
  assign o_load_done  = load_done_q;
  assign o_error      = error_q;
  assign o_word_count = count_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed byte streams with a write scoreboard for a full-size and a 4-word loader
module tb_program_loader;
  typedef struct {
    logic [10:0] a;
    logic [31:0] d;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00, rx_data4 = 8'h00;
  logic        rx_done = 1'b0, rx_done4 = 1'b0;
  logic        wr_en, cpu_rst, load_done, error;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic [11:0] word_count;
  logic        wr_en4, cpu_rst4, load_done4, error4;
  logic [1:0]  wr_addr4;
  logic [31:0] wr_data4;
  logic [2:0]  word_count4;
  exp_t        q[$], q4[$];
  int          total = 0, bad = 0;
  logic        prev_en = 1'b0, prev_en4 = 1'b0;
  always #5 clk = ~clk;
  program_loader dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_cpu_rst(cpu_rst),
    .o_load_done(load_done), .o_error(error), .o_word_count(word_count)
  );
  program_loader #(.RAM_DEPTH_PROGRAM(4), .NB_PC_ADDR(2)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data4), .i_rx_done(rx_done4),
    .o_wr_en(wr_en4), .o_wr_addr(wr_addr4), .o_wr_data(wr_data4), .o_cpu_rst(cpu_rst4),
    .o_load_done(load_done4), .o_error(error4), .o_word_count(word_count4)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [7:0] b, input bit sel);
    if (sel) begin rx_data4 = b; rx_done4 = 1'b1; end
    else begin rx_data = b; rx_done = 1'b1; end
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_done4 = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w, input bit sel, input int gap);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      strobe(v[31:24], sel);
      v = v << 8;
      if (gap > 0) idle(gap);
    end
  endtask
  task automatic expect_wr(input logic [10:0] a, input logic [31:0] d, input bit sel);
    exp_t e;
    e.a = a;
    e.d = d;
    if (sel) q4.push_back(e);
    else q.push_back(e);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (wr_en) begin
      chk("wr_en_width", {63'd0, prev_en}, 64'd0);
      if (q.size() == 0) chk("unexpected_write", {53'd0, wr_addr}, 64'hDEAD);
      else begin
        e = q.pop_front();
        chk("wr_addr", {53'd0, wr_addr}, {53'd0, e.a});
        chk("wr_data", {32'd0, wr_data}, {32'd0, e.d});
      end
    end
    prev_en = wr_en;
  end
  always @(negedge clk) begin
    exp_t e;
    if (wr_en4) begin
      chk("wr_en4_width", {63'd0, prev_en4}, 64'd0);
      if (q4.size() == 0) chk("unexpected_write4", {62'd0, wr_addr4}, 64'hDEAD);
      else begin
        e = q4.pop_front();
        chk("wr_addr4", {62'd0, wr_addr4}, {53'd0, e.a});
        chk("wr_data4", {32'd0, wr_data4}, {32'd0, e.d});
      end
    end
    prev_en4 = wr_en4;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    idle(2);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_addr", {53'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
    chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rst_load_done", {63'd0, load_done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_count", {52'd0, word_count}, 64'd0);
    chk("rst_cpu_rst4", {63'd0, cpu_rst4}, 64'd1);
    rst = 1'b0;
    idle(20);
    chk("idle_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    // back-to-back strobes: the first HALT byte lands in the first write cycle
    expect_wr(11'd0, 32'h20080005, 1'b0);
    expect_wr(11'd1, 32'hFFFFFFFF, 1'b0);
    strobe(8'h01, 1'b0);
    send_word(32'h20080005, 1'b0, 0);
    send_word(32'hFFFFFFFF, 1'b0, 0);
    chk("halt_t1_load_done", {63'd0, load_done}, 64'd0);
    chk("halt_t1_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    idle(1);
    chk("halt_load_done", {63'd0, load_done}, 64'd1);
    chk("halt_cpu_rst", {63'd0, cpu_rst}, 64'd0);
    chk("halt_count", {52'd0, word_count}, 64'd2);
    send_word(32'h20202020, 1'b0, 0);
    idle(3);
    chk("done_ignores_load_done", {63'd0, load_done}, 64'd1);
    chk("done_ignores_count", {52'd0, word_count}, 64'd2);
    strobe(8'h01, 1'b0);
    chk("reload_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("reload_load_done", {63'd0, load_done}, 64'd0);
    chk("reload_count", {52'd0, word_count}, 64'd0);
    chk("reload_addr", {53'd0, wr_addr}, 64'd0);
    expect_wr(11'd0, 32'h12345678, 1'b0);
    send_word(32'h12345678, 1'b0, 1);
    idle(2);
    chk("reload_count1", {52'd0, word_count}, 64'd1);
    do_reset();
    strobe(8'h55, 1'b0);
    strobe(8'hAA, 1'b0);
    idle(2);
    chk("idle_junk_count", {52'd0, word_count}, 64'd0);
    expect_wr(11'd0, 32'h00000000, 1'b0);
    strobe(8'h01, 1'b0);
    send_word(32'h00000000, 1'b0, 1);
    idle(3);
    chk("zero_word_count", {52'd0, word_count}, 64'd1);
    chk("zero_word_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("zero_word_load_done", {63'd0, load_done}, 64'd0);
    strobe(8'h01, 1'b0);
    strobe(8'hAB, 1'b0);
    strobe(8'hCD, 1'b0);
    do_reset();
    chk("midreset_count", {52'd0, word_count}, 64'd0);
    expect_wr(11'd0, 32'h11223344, 1'b0);
    strobe(8'h01, 1'b0);
    send_word(32'h11223344, 1'b0, 0);
    idle(3);
    chk("midreset_count1", {52'd0, word_count}, 64'd1);
    strobe(8'h01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      expect_wr(11'(i), 32'h0000000A + 32'(i), 1'b1);
      send_word(32'h0000000A + 32'(i), 1'b1, 0);
    end
    chk("ovf_t1_error", {63'd0, error4}, 64'd0);
    idle(1);
    chk("ovf_error", {63'd0, error4}, 64'd1);
    chk("ovf_cpu_rst", {63'd0, cpu_rst4}, 64'd1);
    chk("ovf_load_done", {63'd0, load_done4}, 64'd0);
    chk("ovf_count", {61'd0, word_count4}, 64'd4);
    chk("ovf_addr_hold", {62'd0, wr_addr4}, 64'd3);
    for (int i = 0; i < 8; i++) strobe(8'h01, 1'b1);
    idle(3);
    chk("ovf_error_sticky", {63'd0, error4}, 64'd1);
    chk("ovf_count_sticky", {61'd0, word_count4}, 64'd4);
    chk("sb_drain", 64'(q.size()), 64'd0);
    chk("sb4_drain", 64'(q4.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
